// File: rtl/mealy_table_pkg.sv
// Shared types, default widths and the state-width helper for the table-driven Mealy FSM.
package mealy_table_pkg;

    function automatic int unsigned calc_sw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_NUM_STATES = 6;
    localparam int unsigned DEF_IN_W       = 1;
    localparam int unsigned DEF_OUT_W      = 1;
    localparam int unsigned DEF_SW         = calc_sw(DEF_NUM_STATES);

    typedef struct packed {
        logic [DEF_SW-1:0]    next;
        logic [DEF_OUT_W-1:0] out;
    } entry_t;

    localparam entry_t DEFAULT_ENTRY = '0;

endpackage

// File: rtl/mealy_table_mem.sv
// Transition/output table: flop array with range-checked synchronous write, synchronous
// active-low clear and an asynchronous read port indexed by {state, x}.
module mealy_table_mem
    import mealy_table_pkg::*;
#(
    parameter int unsigned NUM_STATES  = DEF_NUM_STATES,
    parameter int unsigned IN_W        = DEF_IN_W,
    parameter int unsigned OUT_W       = DEF_OUT_W,
    parameter int unsigned RESET_STATE = 0,
    localparam int unsigned SW         = calc_sw(NUM_STATES)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [SW-1:0]         wr_state_i,
    input  logic [IN_W-1:0]       wr_in_i,
    input  logic [SW-1:0]         wr_next_i,
    input  logic [OUT_W-1:0]      wr_out_i,
    output logic                  wr_err_o,
    input  logic [SW-1:0]         rd_state_i,
    input  logic [IN_W-1:0]       rd_in_i,
    output logic [SW+OUT_W-1:0]   rd_data_o
);

    localparam int unsigned EW    = SW + OUT_W;
    localparam int unsigned AW    = SW + IN_W;
    localparam int unsigned DEPTH = NUM_STATES * (2 ** IN_W);
    localparam logic [SW:0]   NS  = (SW + 1)'(NUM_STATES);
    localparam logic [EW-1:0] DEF = {SW'(RESET_STATE), OUT_W'(0)};

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic          wr_ok;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign wr_ok    = wr_en_i && ({1'b0, wr_state_i} < NS);
    assign wr_err_o = wr_en_i && !wr_ok;
    assign wr_addr  = {wr_state_i, wr_in_i};
    assign rd_addr  = {rd_state_i, rd_in_i};

    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = {wr_next_i, wr_out_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q <= '{default: DEF};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Rows past NUM_STATES do not exist; never index outside the array.
    assign rd_data_o = ({1'b0, rd_state_i} < NS) ? mem_q[rd_addr] : DEF;

endmodule

// File: rtl/mealy_table_fsm.sv
// Table-driven Mealy FSM: state register, step/error logic and output stage.
// Define MEALY_REG_OUT_EN to register outp/outp_valid one cycle after the step edge.
module mealy_table_fsm
    import mealy_table_pkg::*;
#(
    parameter int unsigned NUM_STATES  = DEF_NUM_STATES,
    parameter int unsigned IN_W        = DEF_IN_W,
    parameter int unsigned OUT_W       = DEF_OUT_W,
    parameter int unsigned RESET_STATE = 0,
    localparam int unsigned SW         = calc_sw(NUM_STATES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_state,
    input  logic [IN_W-1:0]  cfg_in,
    input  logic [SW-1:0]    cfg_next,
    input  logic [OUT_W-1:0] cfg_out,
    input  logic             run_en,
    input  logic [IN_W-1:0]  x,
    input  logic             x_valid,
    output logic [OUT_W-1:0] outp,
    output logic             outp_valid,
    output logic [SW-1:0]    state_o,
    output logic             err
);

    typedef struct packed {
        logic [SW-1:0]    next;
        logic [OUT_W-1:0] out;
    } row_t;

    localparam logic [SW:0]   NS     = (SW + 1)'(NUM_STATES);
    localparam logic [SW-1:0] RST_ST = SW'(RESET_STATE);

    row_t             ent;
    logic             step;
    logic             next_ok;
    logic             wr_err;
    logic [SW-1:0]    state_q, state_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] outp_c;
    logic             outp_valid_c;

    mealy_table_mem #(
        .NUM_STATES  (NUM_STATES),
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .RESET_STATE (RESET_STATE)
    ) u_mem (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wr_en_i    (cfg_we),
        .wr_state_i (cfg_state),
        .wr_in_i    (cfg_in),
        .wr_next_i  (cfg_next),
        .wr_out_i   (cfg_out),
        .wr_err_o   (wr_err),
        .rd_state_i (state_q),
        .rd_in_i    (x),
        .rd_data_o  (ent)
    );

    assign step    = run_en & x_valid;
    assign next_ok = {1'b0, ent.next} < NS;

    always_comb begin
        state_d = state_q;
        err_d   = err_q | wr_err;
        if (step) begin
            if (next_ok) begin
                state_d = ent.next;
            end else begin
                state_d = RST_ST;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RST_ST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Output shows the table value even on an illegal transition.
    assign outp_c       = step ? ent.out : '0;
    assign outp_valid_c = step;

`ifdef MEALY_REG_OUT_EN
    logic [OUT_W-1:0] outp_q, outp_d;
    logic             outp_valid_q, outp_valid_d;

    always_comb begin
        outp_d       = outp_c;
        outp_valid_d = outp_valid_c;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            outp_q       <= '0;
            outp_valid_q <= 1'b0;
        end else begin
            outp_q       <= outp_d;
            outp_valid_q <= outp_valid_d;
        end
    end

    assign outp       = outp_q;
    assign outp_valid = outp_valid_q;
`else
    assign outp       = outp_c;
    assign outp_valid = outp_valid_c;
`endif

    assign state_o = state_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mealy_table_fsm.sv
// Scoreboard bench for mealy_table_fsm: driver pushes expected outputs from a table model,
// a separate monitor pops them whenever outp_valid is seen.
module tb_mealy_table_fsm;

    localparam int NS = 6;
`ifdef MEALY_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [2:0] cfg_state;
    logic [0:0] cfg_in;
    logic [2:0] cfg_next;
    logic [0:0] cfg_out;
    logic       run_en;
    logic [0:0] x;
    logic       x_valid;
    logic [0:0] outp;
    logic       outp_valid;
    logic [2:0] state_o;
    logic       err;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    int m_next [NS][2];
    int m_out  [NS][2];
    int m_state;
    int m_err;
    int exp_q [$];

    mealy_table_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_state  (cfg_state),
        .cfg_in     (cfg_in),
        .cfg_next   (cfg_next),
        .cfg_out    (cfg_out),
        .run_en     (run_en),
        .x          (x),
        .x_valid    (x_valid),
        .outp       (outp),
        .outp_valid (outp_valid),
        .state_o    (state_o),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < 2; i++) begin
                m_next[s][i] = 0;
                m_out[s][i]  = 0;
            end
        end
        m_state = 0;
        m_err   = 0;
    endtask

    // Called just after a rising edge: drive one cycle, advance the model, check registers.
    task automatic cyc(input bit rst_n, input bit we, input int cs, input int ci, input int cn,
                       input int co, input bit run, input bit xv, input int xx);
        int  n;
        bit  stp;
        reset     = rst_n;
        cfg_we    = we;
        cfg_state = cs[2:0];
        cfg_in    = ci[0:0];
        cfg_next  = cn[2:0];
        cfg_out   = co[0:0];
        run_en    = run;
        x_valid   = xv;
        x         = xx[0:0];
        stp       = run && xv;
        if (stp && (rst_n || !REG_OUT)) exp_q.push_back(m_out[m_state][xx]);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (stp) begin
                n = m_next[m_state][xx];
                if (n >= NS) begin
                    m_state = 0;
                    m_err   = 1;
                end else begin
                    m_state = n;
                end
            end
            if (we) begin
                if (cs >= NS) begin
                    m_err = 1;
                end else begin
                    m_next[cs][ci] = cn;
                    m_out[cs][ci]  = co;
                end
            end
        end
        check("state_o", 32'(state_o), 32'(m_state));
        check("err", 32'(err), 32'(m_err));
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (outp_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL outp_valid_unexpected actual=1 required=0 at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("outp", 32'(outp), 32'(e));
                    end
                end else begin
                    check("outp_valid_idle", 32'(outp_valid), 32'd0);
                    check("outp_idle", 32'(outp), 32'd0);
                end
            end
        end
    end

    initial begin : driver
        int r;
        reset = 1'b0; cfg_we = 1'b0; cfg_state = '0; cfg_in = '0; cfg_next = '0;
        cfg_out = '0; run_en = 1'b0; x = '0; x_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_err", 32'(err), 32'd0);

        // Empty table: every step stays in state 0 emitting 0.
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);

        // Sequence table, then x = 0,0,1 -> states 4,2,1, outputs 0,0,1.
        cyc(1, 1, 0, 0, 4, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 3, 1, 0, 0, 0);
        cyc(1, 1, 4, 0, 2, 0, 0, 0, 0);
        cyc(1, 1, 2, 1, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
        check("seq_state", 32'(state_o), 32'd1);

        // Illegal next state from state 1.
        cyc(1, 1, 1, 0, 7, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        check("illegal_state", 32'(state_o), 32'd0);
        check("illegal_err", 32'(err), 32'd1);

        // Out-of-range row write.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 0, 1, 1, 0, 0, 0);
        check("bad_write_err", 32'(err), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write-during-step to the same entry uses old contents.
        cyc(1, 1, 0, 1, 3, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 5, 0, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);
        check("rewrite_state", 32'(state_o), 32'd5);

        // Reset mid-sequence with a write and a step in flight.
        cyc(1, 1, 2, 0, 3, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 4, 1, 1, 1, 0);
        check("midreset_state", 32'(state_o), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);

        // Randomized traffic against the table model.
        repeat (400) begin
            r = int'($urandom_range(0, 99));
            cyc(r >= 3, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, int'($urandom_range(0, 1)));
        end

        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
